// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the FSM encoding and the bus/bubble constants used by the fetch path.
package inst_fetch_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic BBL_ENABLE  = 1'b1;
  localparam logic BBL_DISABLE = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    IFR_IDLE   = 2'd0,
    IFR_DEMAND = 2'd1,
    IFR_DONE   = 2'd2,
    IFR_PREF   = 2'd3
  } ifr_state_e;

  function automatic logic [INST_ADDR_W-1:0] next_seq_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + INST_ADDR_W'(4);
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Fetch-side (pc/ce/inst/bbl) and memory-side (req/ack) signals of the responder.
// slave is the responder's view; master is the PC generator plus memory.
interface inst_fetch_resp_if #(
  parameter int ADDR_W = 17
);
  import inst_fetch_resp_pkg::*;

  logic [INST_ADDR_W-1:0] pc;
  logic                   ce;
  logic [INST_W-1:0]      inst;
  logic                   inst_valid;
  logic                   bbl;
  logic                   mem_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_ack;
  logic [INST_W-1:0]      mem_rdata;

  modport master (
    output pc, ce, mem_ack, mem_rdata,
    input  inst, inst_valid, bbl, mem_req, mem_addr
  );

  modport slave (
    input  pc, ce, mem_ack, mem_rdata,
    output inst, inst_valid, bbl, mem_req, mem_addr
  );

endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: demand fetch on a miss, one-entry next-sequential prefetch.
// Holds the PC via bbl while a demand (or a blocking prefetch) is outstanding.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  inst_fetch_resp_if.slave bus
);

  ifr_state_e state_q, state_d;

  logic              pb_valid;
  logic [ADDR_W-1:0] pb_addr;
  logic [INST_W-1:0] pb_data;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] pf_addr;
  logic [ADDR_W-1:0] dem_addr;

  logic [INST_ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0]      pc_word;
  logic [ADDR_W-1:0]      pc_next_word;
  logic                   hit;
  logic                   fetch_on;

  logic              dem_load, inst_load, pf_from_pc, pf_from_dem, pb_load;
  logic [INST_W-1:0] inst_c;
  logic              inst_valid_c, bbl_c, mem_req_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic              unused_pc_bits;

  assign pc_next      = next_seq_pc(bus.pc);
  assign pc_word      = bus.pc[ADDR_W+1:2];
  assign pc_next_word = pc_next[ADDR_W+1:2];
  assign hit          = pb_valid && (pb_addr == pc_word);
  assign fetch_on     = (bus.ce == CHIP_ENABLE);

  // Byte offset and bits above the word address never select anything.
  assign unused_pc_bits = ^{bus.pc[1:0], bus.pc[INST_ADDR_W-1:ADDR_W+2],
                            pc_next[1:0], pc_next[INST_ADDR_W-1:ADDR_W+2]};

  always_comb begin
    state_d      = state_q;
    inst_c       = '0;
    inst_valid_c = 1'b0;
    bbl_c        = BBL_DISABLE;
    mem_req_c    = 1'b0;
    mem_addr_c   = '0;
    dem_load     = 1'b0;
    inst_load    = 1'b0;
    pf_from_pc   = 1'b0;
    pf_from_dem  = 1'b0;
    pb_load      = 1'b0;
    case (state_q)
      IFR_IDLE: begin
        if (fetch_on) begin
          if (hit) begin
            inst_c       = pb_data;
            inst_valid_c = 1'b1;
            if (PREFETCH_EN) begin
              pf_from_pc = 1'b1;
              state_d    = IFR_PREF;
            end
          end else begin
            bbl_c    = BBL_ENABLE;
            dem_load = 1'b1;
            state_d  = IFR_DEMAND;
          end
        end
      end
      IFR_DEMAND: begin
        mem_req_c  = 1'b1;
        mem_addr_c = dem_addr;
        bbl_c      = BBL_ENABLE;
        // Data for a fetch that was withdrawn is dropped, not delivered later.
        if (bus.mem_ack) begin
          if (fetch_on) begin
            inst_load = 1'b1;
            state_d   = IFR_DONE;
          end else begin
            state_d = IFR_IDLE;
          end
        end
      end
      IFR_DONE: begin
        inst_c       = inst_q;
        inst_valid_c = 1'b1;
        if (PREFETCH_EN && fetch_on) begin
          pf_from_dem = 1'b1;
          state_d     = IFR_PREF;
        end else begin
          state_d = IFR_IDLE;
        end
      end
      IFR_PREF: begin
        mem_req_c  = 1'b1;
        mem_addr_c = pf_addr;
        bbl_c      = fetch_on ? BBL_ENABLE : BBL_DISABLE;
        if (bus.mem_ack) begin
          pb_load = 1'b1;
          state_d = IFR_IDLE;
        end
      end
      default: state_d = IFR_IDLE;
    endcase
    // Reset must quiet the outputs immediately, whatever ce/pc are doing.
    if (rst) begin
      inst_c       = '0;
      inst_valid_c = 1'b0;
      bbl_c        = BBL_DISABLE;
      mem_req_c    = 1'b0;
      mem_addr_c   = '0;
    end
  end

  assign bus.inst       = inst_c;
  assign bus.inst_valid = inst_valid_c;
  assign bus.bbl        = bbl_c;
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_addr   = mem_addr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IFR_IDLE;
      pb_valid <= 1'b0;
      pb_addr  <= '0;
      pb_data  <= '0;
      inst_q   <= '0;
      pf_addr  <= '0;
      dem_addr <= '0;
    end else begin
      state_q <= state_d;
      if (dem_load)    dem_addr <= pc_word;
      if (inst_load)   inst_q   <= bus.mem_rdata;
      if (pf_from_pc)  pf_addr  <= pc_next_word;
      if (pf_from_dem) pf_addr  <= dem_addr + ADDR_W'(1);
      if (pb_load) begin
        pb_valid <= 1'b1;
        pb_addr  <= pf_addr;
        pb_data  <= bus.mem_rdata;
      end
    end
  end

endmodule
